// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and small op-classification helpers.
package hilo_muldiv_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MSUB  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic mdu_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV) || (o == MDU_MADD) || (o == MDU_MSUB);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_cond_negate.sv
// Combinational conditional two's-complement negator, used both to take operand
// magnitudes and to restore the sign of results.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO pair.
// One bit per cycle: radix-2 shift-add multiply, restoring divide on magnitudes.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  mdu_op_e            op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;

  mdu_op_e            op_in;
  logic               sgn_in;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in  = mdu_op_e'(op);
  assign sgn_in = mdu_is_signed(op_in);

  cond_negate #(.WIDTH(WIDTH)) u_neg_rs (
    .in_i(rs_val), .neg_i(sgn_in & rs_val[WIDTH-1]), .out_o(rs_mag)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_rt (
    .in_i(rt_val), .neg_i(sgn_in & rt_val[WIDTH-1]), .out_o(rt_mag)
  );
  cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in_i(acc_q), .neg_i(neg_res_q), .out_o(prod_fix)
  );
  cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .in_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .out_o(quo_fix)
  );
  cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .out_o(rem_fix)
  );

  // One multiply iteration: conditionally add multiplicand, shift right one place
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide iteration; the shifted remainder needs WIDTH+1 bits
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_qbit  = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_qbit ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
  assign div_step  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    b_d       = b_q;
    rs_d      = rs_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          case (op_in)
            MDU_MTHI: begin
              hi_d    = rs_val;
              state_d = ST_DONE;
            end
            MDU_MTLO: begin
              lo_d    = rs_val;
              state_d = ST_DONE;
            end
            default: begin
              state_d   = ST_CALC;
              cnt_d     = '0;
              op_d      = op_in;
              rs_d      = rs_val;
              neg_res_d = sgn_in & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem_d = sgn_in & rs_val[WIDTH-1];
              if (mdu_is_div(op_in)) begin
                acc_d = {{WIDTH{1'b0}}, rs_mag};
                b_d   = rt_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, rt_mag};
                b_d   = rs_mag;
              end
            end
          endcase
        end
      end
      ST_CALC: begin
        acc_d = mdu_is_div(op_q) ? div_step : mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        case (op_q)
          MDU_MULT, MDU_MULTU: {hi_d, lo_d} = prod_fix;
          MDU_MADD:            {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          MDU_MSUB:            {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
          MDU_DIV, MDU_DIVU: begin
            // Divide by zero leaves the dividend in HI and all-ones in LO
            if (b_q == '0) begin
              hi_d = rs_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    b_q       <= b_d;
    rs_q      <= rs_d;
    op_q      <= op_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
